prog_clock_divider: RTL and testbench

Programmable integer clock divider producing a divided clock-level signal (clk_out) and a one-cycle period strobe (tick), all in the clk domain.
- Divide ratio is run-time loadable.
- A new ratio takes effect only at a period boundary, so no runt periods appear on clk_out.
- Serves as the parametrised successor to the fixed power-of-two divider and feeds baud/timer/LED-blink enables.

---
 rtl/prog_clock_divider.sv | 101 ++++++++++
 tb/tb_prog_clock_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - programmable integer clock divider with boundary-aligned ratio reload
// Optional power-of-two tap outputs enabled by defining CLKDIV_POW2_TAPS_EN.
module prog_clock_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4,
    parameter int NUM_TAPS    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [WIDTH-1:0]    div_in,
    input  logic                div_load,
    output logic                div_busy,
    output logic                clk_out,
    output logic                tick,
    output logic [NUM_TAPS-1:0] taps
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RESET_CNT = (DEFAULT_DIV == 0) ? '0 : WIDTH'(DEFAULT_DIV - 1);

    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_cnt;
    logic [WIDTH:0]   high;
    logic [WIDTH:0]   cnt_inc;
    logic             wrap;
    logic             short_div;

    // High-phase length is ceil(N/2); the extra bit keeps N = 2^WIDTH-1 from overflowing.
    always_comb begin
        high      = ({1'b0, active_div} + (WIDTH+1)'(1)) >> 1;
        cnt_inc   = {1'b0, cnt} + (WIDTH+1)'(1);
        wrap      = (active_div != '0) && (cnt == active_div - WIDTH'(1));
        short_div = (active_div <= WIDTH'(1));
        pend_cnt  = (pend == '0) ? '0 : pend - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_div <= RESET_DIV;
            cnt        <= RESET_CNT;
            pend       <= '0;
            div_busy   <= 1'b0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (div_busy && !en) begin
                // Parked apply: cnt is primed so the next enabled edge is a wrap.
                active_div <= pend;
                cnt        <= pend_cnt;
                clk_out    <= 1'b0;
                div_busy   <= 1'b0;
            end else if (div_busy && (wrap || short_div)) begin
                active_div <= pend;
                cnt        <= '0;
                clk_out    <= (pend != '0);
                tick       <= (pend != '0);
                div_busy   <= 1'b0;
            end else if (en) begin
                if (active_div == '0) begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                end else if (wrap) begin
                    cnt     <= '0;
                    clk_out <= 1'b1;
                    tick    <= 1'b1;
                end else begin
                    cnt     <= cnt_inc[WIDTH-1:0];
                    clk_out <= (cnt_inc < high);
                end
            end
            // A load on an apply edge queues behind the value being applied.
            if (div_load) begin
                pend     <= div_in;
                div_busy <= 1'b1;
            end
        end
    end

`ifdef CLKDIV_POW2_TAPS_EN
    logic [NUM_TAPS-1:0] tap_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt <= '0;
            taps    <= '0;
        end else begin
            if (en) begin
                tap_cnt <= tap_cnt + NUM_TAPS'(1);
            end
            taps <= tap_cnt;
        end
    end
`else
    assign taps = '0;
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - self-checking bench for prog_clock_divider
module tb_prog_clock_divider;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 4;
    localparam int NUM_TAPS    = 4;
`ifdef CLKDIV_POW2_TAPS_EN
    localparam bit TAPS_EN = 1'b1;
`else
    localparam bit TAPS_EN = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                en;
    logic [WIDTH-1:0]    div_in;
    logic                div_load;
    logic                div_busy;
    logic                clk_out;
    logic                tick;
    logic [NUM_TAPS-1:0] taps;

    int checks = 0;
    int errors = 0;

    prog_clock_divider #(
        .WIDTH(WIDTH), .DEFAULT_DIV(DEFAULT_DIV), .NUM_TAPS(NUM_TAPS)
    ) dut (
        .clk(clk), .rst(rst_n), .en(en), .div_in(div_in), .div_load(div_load),
        .div_busy(div_busy), .clk_out(clk_out), .tick(tick), .taps(taps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             en;
        logic             ld;
        logic [WIDTH-1:0] din;
        logic             c;
        logic             t;
        logic             b;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e, input logic ld, input logic [WIDTH-1:0] d,
                       input logic c, input logic t, input logic b);
        vec_t v;
        v.en = e; v.ld = ld; v.din = d; v.c = c; v.t = t; v.b = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each period is expanded into a queue of {clk_out,tick} samples.
    int unsigned     m_n;
    int unsigned     m_pend;
    bit              m_busy;
    bit              m_clk;
    bit              m_tick;
    logic [1:0]      m_q[$];
    int unsigned     m_tap_cnt;
    logic [NUM_TAPS-1:0] m_taps;

    task automatic model_reset();
        m_n = DEFAULT_DIV; m_pend = 0; m_busy = 0; m_clk = 0; m_tick = 0;
        m_q.delete(); m_tap_cnt = 0; m_taps = '0;
    endtask

    task automatic model_edge(input logic e, input logic ld, input logic [WIDTH-1:0] d);
        logic [1:0] v;
        if (e) begin
            if (m_q.size() == 0) begin
                if (m_busy) begin
                    m_n = m_pend;
                    m_busy = 0;
                end
                for (int i = 0; i < int'(m_n); i++)
                    m_q.push_back({(i < int'((m_n + 1) / 2)), (i == 0)});
            end
            if (m_q.size() != 0) begin
                v = m_q.pop_front();
                m_clk = v[1];
                m_tick = v[0];
            end else begin
                m_clk = 0;
                m_tick = 0;
            end
        end else begin
            m_tick = 0;
            if (m_busy) begin
                m_n = m_pend;
                m_busy = 0;
                m_q.delete();
                m_clk = 0;
            end
        end
        if (ld) begin
            m_pend = d;
            m_busy = 1;
        end
        m_taps = TAPS_EN ? NUM_TAPS'(m_tap_cnt) : '0;
        if (e) m_tap_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;

        // Directed rows: {en, load, div_in} -> {clk_out, tick, div_busy} after the edge.
        add(1,0,0, 1,1,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 1,1,0);
        add(1,1,5, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 1,1,0); add(1,0,0, 1,0,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 0,0,0); add(1,0,0, 1,1,0);
        add(1,1,6, 1,0,1); add(1,1,3, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,1);
        add(1,0,0, 1,1,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 1,1,0);
        add(1,0,0, 1,0,0);
        for (int i = 0; i < 5; i++) add(0,0,0, 1,0,0);
        add(1,0,0, 0,0,0); add(1,0,0, 1,1,0);
        add(1,1,0, 1,0,1); add(1,0,0, 0,0,1); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,0,0, 0,0,0);
        add(1,1,1, 0,0,1); add(1,0,0, 1,1,0); add(1,0,0, 1,1,0); add(1,0,0, 1,1,0);
        add(0,1,4, 1,0,1); add(0,0,0, 0,0,0);
        add(1,0,0, 1,1,0); add(1,0,0, 1,0,0); add(1,0,0, 0,0,0); add(1,0,0, 0,0,0);
        add(1,1,7, 1,1,1);

        repeat (2) step();
        chk("reset_state", {clk_out, tick, div_busy, taps}, '0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            en = vq[i].en; div_load = vq[i].ld; div_in = vq[i].din;
            step();
            chk($sformatf("vec%0d", i + 1), {clk_out, tick, div_busy},
                {vq[i].c, vq[i].t, vq[i].b});
        end
        en = 1'b1; div_load = 1'b0; div_in = '0;

        // Asynchronous reset between edges while high, ticking and busy.
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {clk_out, tick, div_busy, taps}, '0);
        #2 rst_n = 1'b1;
        begin
            logic [2:0] exp_seq [5];
            exp_seq[0] = 3'b110; exp_seq[1] = 3'b100; exp_seq[2] = 3'b000;
            exp_seq[3] = 3'b000; exp_seq[4] = 3'b110;
            for (int i = 0; i < 5; i++) begin
                step();
                chk($sformatf("post_reset%0d", i), {clk_out, tick, div_busy}, exp_seq[i]);
            end
        end

        // Randomized run against the period-queue model.
        rst_n = 1'b0; en = 1'b0; div_load = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 7) == 0);
            div_in = ($urandom_range(0, 39) == 0) ? WIDTH'($urandom_range(0, 40))
                                                  : WIDTH'($urandom_range(0, 9));
            model_edge(en, div_load, div_in);
            step();
            chk($sformatf("rand%0d", k), {clk_out, tick, div_busy, taps},
                {m_clk, m_tick, m_busy, m_taps});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
